// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard front end.
package ps2_pkg;

  // Scan-code prefix bytes
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Bit positions inside the 10-bit event word {brk,ext,code[7:0]}
  localparam int EV_BRK = 9;
  localparam int EV_EXT = 8;

  // Frame receiver states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } rx_state_t;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: input synchroniser, clock glitch filter, 11-bit frame
// FSM with inter-bit timeout. Emits one-cycle rx_valid / frame_err pulses.
//
// state | meaning
// IDLE  | waiting for a falling PS/2 clock with data low (start bit)
// RECV  | shifting in data[7:0], parity, stop; timeout armed
// CHECK | one cycle: verify stop and odd parity, then back to IDLE
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CYC  = 8,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic       clock_50,
  input  logic       RESET,
  input  logic       PS2_CLOCK,
  input  logic       PS2_DATA,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_s, dat_s;
  logic                   filt_q, filt_d;
  logic [FW-1:0]          flt_cnt_q, flt_cnt_d;
  logic                   fall_q, fall_d;

  rx_state_t              state_q;
  logic [3:0]             bitcnt_q;
  logic [9:0]             shreg_q;
  logic [TW-1:0]          tmr_q;
  logic                   rx_valid_q;
  logic [7:0]             rx_byte_q;
  logic                   frame_err_q;

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  // Synchroniser shift and glitch filter: the filtered clock follows the
  // synchronised clock only after FILTER_CYC consecutive differing samples.
  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], PS2_CLOCK};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], PS2_DATA};
    filt_d     = filt_q;
    flt_cnt_d  = FW'(FILTER_CYC - 1);
    fall_d     = 1'b0;
    if (clk_s != filt_q) begin
      if (flt_cnt_q == '0) begin
        filt_d = clk_s;
        fall_d = ~clk_s;
      end else begin
        flt_cnt_d = flt_cnt_q - 1'b1;
      end
    end
  end

  // Input path registers; lines idle high.
  always_ff @(posedge clock_50 or posedge RESET) begin
    if (RESET) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      filt_q     <= 1'b1;
      flt_cnt_q  <= FW'(FILTER_CYC - 1);
      fall_q     <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      filt_q     <= filt_d;
      flt_cnt_q  <= flt_cnt_d;
      fall_q     <= fall_d;
    end
  end

  // Frame FSM with timeout down-counter; bits land LSB first so after the
  // stop bit shreg holds {stop, parity, data[7:0]}.
  always_ff @(posedge clock_50 or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      tmr_q       <= '0;
      rx_valid_q  <= 1'b0;
      rx_byte_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fall_q && !dat_s) begin
            state_q  <= RECV;
            bitcnt_q <= 4'd1;
            tmr_q    <= TW'(TIMEOUT_CYC - 1);
          end
        end
        RECV: begin
          if (fall_q) begin
            shreg_q  <= {dat_s, shreg_q[9:1]};
            bitcnt_q <= bitcnt_q + 4'd1;
            tmr_q    <= TW'(TIMEOUT_CYC - 1);
            if (bitcnt_q == 4'd10) state_q <= CHECK;
          end else if (tmr_q == '0) begin
            state_q     <= IDLE;
            frame_err_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        CHECK: begin
          state_q <= IDLE;
          if (shreg_q[9] && (^shreg_q[8:0])) begin
            rx_valid_q <= 1'b1;
            rx_byte_q  <= shreg_q[7:0];
          end else begin
            frame_err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_valid  = rx_valid_q;
  assign rx_byte   = rx_byte_q;
  assign frame_err = frame_err_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: frame receiver, make/break/E0 decoder, held-key
// flag table and an ordered event FIFO with registered head outputs.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int                    NUM_KEYS    = 4,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES   = {9'h023, 9'h01B, 9'h01C, 9'h01D},
  parameter int                    SYNC_STAGES = 2,
  parameter int                    FILTER_CYC  = 8,
  parameter int                    TIMEOUT_CYC = 500000,
  parameter int                    FIFO_DEPTH  = 8
) (
  input  logic                clock_50,
  input  logic                RESET,
  input  logic                PS2_CLOCK,
  input  logic                PS2_DATA,
  output logic [NUM_KEYS-1:0] key_flags,
  output logic                ev_valid,
  output logic [9:0]          ev_data,
  input  logic                ev_pop,
  output logic                ev_overflow,
  output logic                frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic          rx_valid;
  logic [7:0]    rx_byte;
  logic          rx_frame_err;

  logic          ext_pend_q, ext_pend_d;
  logic          brk_pend_q, brk_pend_d;
  logic          push_req;
  logic [9:0]    ev_new;
  logic [NUM_KEYS-1:0] key_flags_q, key_flags_d;

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          fifo_empty, fifo_full;
  logic          pop_ok, push_ok;
  logic          ev_valid_q, ev_valid_d;
  logic [9:0]    ev_data_q, ev_data_d;
  logic          ev_overflow_q, ev_overflow_d;

  ps2_rx_frame #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_CYC  (FILTER_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clock_50  (clock_50),
    .RESET     (RESET),
    .PS2_CLOCK (PS2_CLOCK),
    .PS2_DATA  (PS2_DATA),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .frame_err (rx_frame_err)
  );

  // Prefix tracking and event formation; flags follow every decoded event,
  // including ones the FIFO has to drop.
  always_comb begin
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    push_req    = 1'b0;
    ev_new      = '0;
    key_flags_d = key_flags_q;
    if (rx_valid) begin
      case (rx_byte)
        PS2_EXT:   ext_pend_d = 1'b1;
        PS2_BRK:   brk_pend_d = 1'b1;
        PS2_PAUSE: begin
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end
        default: begin
          push_req        = 1'b1;
          ev_new[7:0]     = rx_byte;
          ev_new[EV_EXT]  = ext_pend_q;
          ev_new[EV_BRK]  = brk_pend_q;
          ext_pend_d      = 1'b0;
          brk_pend_d      = 1'b0;
        end
      endcase
    end
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (push_req && (ev_new[8:0] == KEY_CODES[i*9 +: 9]))
        key_flags_d[i] = ~ev_new[EV_BRK];
    end
  end

  // FIFO control: pop frees a slot in the same cycle a push needs it; the
  // head register bypasses the memory when the new entry becomes the head.
  always_comb begin
    fifo_empty    = (wr_ptr_q == rd_ptr_q);
    fifo_full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    pop_ok        = ev_pop && !fifo_empty;
    push_ok       = push_req && (!fifo_full || pop_ok);
    ev_overflow_d = push_req && fifo_full && !pop_ok;
    wr_ptr_d      = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d      = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    ev_valid_d    = (wr_ptr_d != rd_ptr_d);
    if (push_ok && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]))
      ev_data_d = ev_new;
    else
      ev_data_d = mem_q[rd_ptr_d[AW-1:0]];
  end

  // FIFO storage; contents need no reset since the head is gated by ev_valid.
  always_ff @(posedge clock_50) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= ev_new;
  end

  // Decoder, flag and FIFO state registers.
  always_ff @(posedge clock_50 or posedge RESET) begin
    if (RESET) begin
      ext_pend_q    <= 1'b0;
      brk_pend_q    <= 1'b0;
      key_flags_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ev_valid_q    <= 1'b0;
      ev_data_q     <= '0;
      ev_overflow_q <= 1'b0;
    end else begin
      ext_pend_q    <= ext_pend_d;
      brk_pend_q    <= brk_pend_d;
      key_flags_q   <= key_flags_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ev_valid_q    <= ev_valid_d;
      ev_data_q     <= ev_data_d;
      ev_overflow_q <= ev_overflow_d;
    end
  end

  assign key_flags   = key_flags_q;
  assign ev_valid    = ev_valid_q;
  assign ev_data     = ev_data_q;
  assign ev_overflow = ev_overflow_q;
  assign frame_err   = rx_frame_err;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: make/break, extended keys, parity and
// timeout errors, FIFO overflow and pop+push at full, mid-frame reset, glitches.
module tb_ps2_key_tracker;

  logic       clock_50 = 1'b0;
  logic       RESET = 1'b1;
  logic       PS2_CLOCK = 1'b1;
  logic       PS2_DATA = 1'b1;
  logic [3:0] key_flags;
  logic       ev_valid;
  logic [9:0] ev_data;
  logic       ev_pop = 1'b0;
  logic       ev_overflow;
  logic       frame_err;

  int tests = 0;
  int fails = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;
  int fe0, ov0, waitn;
  logic [9:0] exp_q [8];

  ps2_key_tracker #(
    .NUM_KEYS    (4),
    .KEY_CODES   ({9'h023, 9'h01B, 9'h175, 9'h01D}),
    .SYNC_STAGES (2),
    .FILTER_CYC  (8),
    .TIMEOUT_CYC (1000),
    .FIFO_DEPTH  (8)
  ) u_dut (
    .clock_50    (clock_50),
    .RESET       (RESET),
    .PS2_CLOCK   (PS2_CLOCK),
    .PS2_DATA    (PS2_DATA),
    .key_flags   (key_flags),
    .ev_valid    (ev_valid),
    .ev_data     (ev_data),
    .ev_pop      (ev_pop),
    .ev_overflow (ev_overflow),
    .frame_err   (frame_err)
  );

  always #10 clock_50 = ~clock_50;

  // Pulse counters (cycles high) for the one-cycle strobes.
  always @(negedge clock_50) begin
    if (frame_err)   ferr_cnt <= ferr_cnt + 1;
    if (ev_overflow) ovf_cnt  <= ovf_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock_50);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input bit glitch);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2_DATA = f[i];
      cyc(10);
      PS2_CLOCK = 1'b0;
      cyc(20);
      PS2_CLOCK = 1'b1;
      if (glitch) begin
        cyc(4);
        PS2_CLOCK = 1'b0;
        cyc(3);
        PS2_CLOCK = 1'b1;
        cyc(3);
      end else begin
        cyc(10);
      end
    end
    PS2_DATA = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 11, 1'b0);
    cyc(30);
  endtask

  task automatic pop_one();
    ev_pop = 1'b1;
    cyc(1);
    ev_pop = 1'b0;
  endtask

  initial begin
    // Reset state
    cyc(5);
    check("rst_flags", 32'(key_flags), 32'h0);
    check("rst_valid", 32'(ev_valid), 32'h0);
    check("rst_ovf",   32'(ev_overflow), 32'h0);
    check("rst_ferr",  32'(frame_err), 32'h0);
    RESET = 1'b0;
    cyc(5);

    // Make / break of slot 0 (1D)
    send_byte(8'h1D);
    check("mk1d_flags", 32'(key_flags), 32'h1);
    check("mk1d_valid", 32'(ev_valid), 32'h1);
    check("mk1d_data",  32'(ev_data), 32'h01D);
    pop_one();
    check("mk1d_popped", 32'(ev_valid), 32'h0);
    send_byte(8'hF0);
    check("brk_pend_noev", 32'(ev_valid), 32'h0);
    send_byte(8'h1D);
    check("bk1d_flags", 32'(key_flags), 32'h0);
    check("bk1d_data",  32'(ev_data), 32'h21D);
    pop_one();

    // Extended key in slot 1 while slot 0 is held
    send_byte(8'h1D);
    pop_one();
    send_byte(8'hE0);
    send_byte(8'h75);
    check("mk175_flags", 32'(key_flags), 32'h3);
    check("mk175_data",  32'(ev_data), 32'h175);
    pop_one();
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    check("bk175_flags", 32'(key_flags), 32'h1);
    check("bk175_data",  32'(ev_data), 32'h375);
    pop_one();

    // Parity error, then a good frame
    fe0 = ferr_cnt;
    send_frame(8'h1C, 1'b1, 11, 1'b0);
    cyc(30);
    check("par_ferr",  32'(ferr_cnt - fe0), 32'd1);
    check("par_noev",  32'(ev_valid), 32'h0);
    check("par_flags", 32'(key_flags), 32'h1);
    send_byte(8'h1C);
    check("par_next_data",  32'(ev_data), 32'h01C);
    check("par_next_valid", 32'(ev_valid), 32'h1);
    pop_one();
    send_byte(8'hF0);
    send_byte(8'h1D);
    check("par_clr_flags", 32'(key_flags), 32'h0);
    pop_one();

    // Timeout after 5 bits, then a full 23 frame
    fe0 = ferr_cnt;
    send_frame(8'h12, 1'b0, 5, 1'b0);
    cyc(900);
    check("to_early", 32'(ferr_cnt - fe0), 32'd0);
    cyc(200);
    check("to_ferr",  32'(ferr_cnt - fe0), 32'd1);
    check("to_noev",  32'(ev_valid), 32'h0);
    send_byte(8'h23);
    check("to_23_flags", 32'(key_flags), 32'h8);
    check("to_23_data",  32'(ev_data), 32'h023);
    pop_one();

    // Overflow: 9 makes into an 8-deep FIFO
    ov0 = ovf_cnt;
    for (int i = 0; i < 9; i++) send_byte(8'(8'h10 + i));
    check("ovf_pulse", 32'(ovf_cnt - ov0), 32'd1);
    check("ovf_valid", 32'(ev_valid), 32'h1);
    check("ovf_head",  32'(ev_data), 32'h010);
    check("ovf_flags", 32'(key_flags), 32'h8);

    // Pop in the same cycle the next event is pushed into the full FIFO
    waitn = 0;
    fork
      send_frame(8'h19, 1'b0, 11, 1'b0);
      begin
        while (!u_dut.rx_valid && waitn < 600) begin
          cyc(1);
          waitn++;
        end
        ev_pop = 1'b1;
        cyc(1);
        ev_pop = 1'b0;
      end
    join
    cyc(30);
    check("pp_wait", 32'(waitn < 600), 32'h1);
    check("pp_no_ovf", 32'(ovf_cnt - ov0), 32'd1);
    exp_q = '{10'h011, 10'h012, 10'h013, 10'h014, 10'h015, 10'h016, 10'h017, 10'h019};
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_valid%0d", i), 32'(ev_valid), 32'h1);
      check($sformatf("drain_data%0d", i),  32'(ev_data), 32'(exp_q[i]));
      pop_one();
    end
    check("drain_empty", 32'(ev_valid), 32'h0);

    // Reset in the middle of a frame
    send_byte(8'h1D);
    check("pre_rst_flags", 32'(key_flags), 32'h9);
    send_frame(8'h55, 1'b0, 7, 1'b0);
    RESET = 1'b1;
    cyc(3);
    check("mid_rst_flags", 32'(key_flags), 32'h0);
    check("mid_rst_valid", 32'(ev_valid), 32'h0);
    RESET = 1'b0;
    cyc(5);
    send_byte(8'h1D);
    check("post_rst_flags", 32'(key_flags), 32'h1);
    check("post_rst_data",  32'(ev_data), 32'h01D);
    pop_one();

    // Short clock glitches while idle and inside frames are ignored
    fe0 = ferr_cnt;
    PS2_DATA = 1'b0;
    for (int i = 0; i < 5; i++) begin
      PS2_CLOCK = 1'b0;
      cyc(3);
      PS2_CLOCK = 1'b1;
      cyc(10);
    end
    PS2_DATA = 1'b1;
    cyc(20);
    check("gl_idle_noev", 32'(ev_valid), 32'h0);
    send_frame(8'hF0, 1'b0, 11, 1'b1);
    cyc(30);
    send_frame(8'h1D, 1'b0, 11, 1'b1);
    cyc(30);
    check("gl_ferr",  32'(ferr_cnt - fe0), 32'd0);
    check("gl_flags", 32'(key_flags), 32'h0);
    check("gl_data",  32'(ev_data), 32'h21D);
    check("gl_valid", 32'(ev_valid), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
